// File: rtl/fifo_window_select.sv
// Circular buffer head/tail owner that picks up to GRANTS requesting live entries
// per cycle (oldest- or youngest-first) and presents them through a registered stage.
module fifo_window_select #(
    parameter int    ADDR_WIDTH = 5,
    parameter int    SLOTS      = 1 << ADDR_WIDTH,
    parameter int    GRANTS     = 2,
    parameter string CLOSEST_TO = "head"
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    output logic [ADDR_WIDTH-1:0]        alloc_index,
    input  logic                         retire_valid,
    output logic [ADDR_WIDTH-1:0]        retire_index,
    input  logic [SLOTS-1:0]             requests,
    output logic [GRANTS-1:0]            sel_valid,
    output logic [GRANTS*ADDR_WIDTH-1:0] sel_index,
    input  logic                         sel_ready,
    output logic [ADDR_WIDTH:0]          count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW       = ADDR_WIDTH + 1;
    localparam bit YOUNGEST = (CLOSEST_TO == "tail");

    logic [PW-1:0]                  head;
    logic [PW-1:0]                  tail;
    logic [SLOTS-1:0]               granted;
    logic [SLOTS-1:0]               granted_next;
    logic [SLOTS-1:0]               live;
    logic [SLOTS-1:0]               eligible;
    logic [SLOTS-1:0]               rot;
    logic [SLOTS-1:0]               remaining;
    logic [ADDR_WIDTH-1:0]          head_low;
    logic [ADDR_WIDTH-1:0]          tail_low;
    logic [ADDR_WIDTH-1:0]          base;
    logic [ADDR_WIDTH-1:0]          found;
    logic                           hit;
    logic [GRANTS-1:0]              nxt_valid;
    logic [GRANTS*ADDR_WIDTH-1:0]   nxt_index;
    logic                           do_alloc;
    logic                           do_retire;
    logic                           load;

    assign head_low     = head[ADDR_WIDTH-1:0];
    assign tail_low     = tail[ADDR_WIDTH-1:0];
    assign count        = tail - head;
    assign empty        = (head == tail);
    assign full         = (head_low == tail_low) && (head[ADDR_WIDTH] != tail[ADDR_WIDTH]);
    assign alloc_ready  = !full;
    assign alloc_index  = tail_low;
    assign retire_index = head_low;
    assign do_alloc     = alloc_valid && !full;
    assign do_retire    = retire_valid && !empty;
    assign load         = !(|sel_valid) || sel_ready;

    // Scan origin: oldest entry for head mode, youngest entry for tail mode.
    assign base = YOUNGEST ? (tail_low - ADDR_WIDTH'(1)) : head_low;

    // Distance from head below count means live; this also covers the full case.
    always_comb begin
        live = '0;
        for (int s = 0; s < SLOTS; s++) begin
            live[s] = {1'b0, ADDR_WIDTH'(ADDR_WIDTH'(s) - head_low)} < count;
        end
    end

    assign eligible = requests & live & ~granted;

    // Rotate so that bit 0 is the scan origin and higher bits move along the scan direction.
    always_comb begin
        rot = '0;
        for (int k = 0; k < SLOTS; k++) begin
            rot[k] = YOUNGEST ? eligible[base - ADDR_WIDTH'(k)]
                              : eligible[base + ADDR_WIDTH'(k)];
        end
    end

    always_comb begin
        nxt_valid = '0;
        nxt_index = '0;
        remaining = rot;
        hit       = 1'b0;
        found     = '0;
        for (int g = 0; g < GRANTS; g++) begin
            hit   = 1'b0;
            found = '0;
            for (int k = SLOTS - 1; k >= 0; k--) begin
                if (remaining[k]) begin
                    hit   = 1'b1;
                    found = ADDR_WIDTH'(k);
                end
            end
            if (hit) begin
                remaining[found] = 1'b0;
                nxt_valid[g]     = 1'b1;
                nxt_index[g*ADDR_WIDTH +: ADDR_WIDTH] = YOUNGEST ? (base - found) : (base + found);
            end
        end
    end

    // A freshly allocated slot is never live, so its clear cannot collide with a grant.
    always_comb begin
        granted_next = granted;
        if (do_alloc) begin
            granted_next[tail_low] = 1'b0;
        end
        if (load) begin
            for (int g = 0; g < GRANTS; g++) begin
                if (nxt_valid[g]) begin
                    granted_next[nxt_index[g*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            granted   <= '0;
            sel_valid <= '0;
            sel_index <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            granted   <= '0;
            sel_valid <= '0;
            sel_index <= '0;
        end else begin
            if (do_alloc) begin
                tail <= tail + PW'(1);
            end
            if (do_retire) begin
                head <= head + PW'(1);
            end
            if (load) begin
                sel_valid <= nxt_valid;
                sel_index <= nxt_index;
            end
            granted <= granted_next;
        end
    end

endmodule

// File: tb/tb_fifo_window_select.sv
// Directed bench for fifo_window_select: one oldest-first and one youngest-first
// instance share stimulus so both scan orders are checked against hand values.
module tb_fifo_window_select;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic        retire_valid;
    logic [31:0] requests;
    logic        sel_ready;

    logic        alloc_ready_h, empty_h, full_h;
    logic [4:0]  alloc_index_h, retire_index_h;
    logic [1:0]  sel_valid_h;
    logic [9:0]  sel_index_h;
    logic [5:0]  count_h;

    logic        alloc_ready_t, empty_t, full_t;
    logic [4:0]  alloc_index_t, retire_index_t;
    logic [1:0]  sel_valid_t;
    logic [9:0]  sel_index_t;
    logic [5:0]  count_t;

    int checks = 0;
    int errors = 0;

    fifo_window_select #(.ADDR_WIDTH(5), .GRANTS(2), .CLOSEST_TO("head")) dut_h (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready_h), .alloc_index(alloc_index_h),
        .retire_valid(retire_valid), .retire_index(retire_index_h),
        .requests(requests), .sel_valid(sel_valid_h), .sel_index(sel_index_h),
        .sel_ready(sel_ready), .count(count_h), .empty(empty_h), .full(full_h)
    );

    fifo_window_select #(.ADDR_WIDTH(5), .GRANTS(2), .CLOSEST_TO("tail")) dut_t (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready_t), .alloc_index(alloc_index_t),
        .retire_valid(retire_valid), .retire_index(retire_index_t),
        .requests(requests), .sel_valid(sel_valid_t), .sel_index(sel_index_t),
        .sel_ready(sel_ready), .count(count_t), .empty(empty_t), .full(full_t)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (count_h !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_h); end
        checks++; if (empty_h !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty_h); end
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full_h); end
        checks++; if (alloc_ready_h !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready_h); end
        checks++; if (sel_valid_h !== 2'b00) begin errors++; $display("FAIL reset_sel_valid: got %b expected 00", sel_valid_h); end
        checks++; if (alloc_index_h !== 5'd0) begin errors++; $display("FAIL reset_alloc_index: got %0d expected 0", alloc_index_h); end
        retire_valid = 1'b1;
        step();
        retire_valid = 1'b0;
        checks++; if (count_h !== 6'd0) begin errors++; $display("FAIL retire_empty_count: got %0d expected 0", count_h); end
        checks++; if (retire_index_h !== 5'd0) begin errors++; $display("FAIL retire_empty_index: got %0d expected 0", retire_index_h); end
    endtask

    task automatic test_select_head();
        sel_ready   = 1'b1;
        alloc_valid = 1'b1;
        repeat (8) step();
        alloc_valid = 1'b0;
        checks++; if (count_h !== 6'd8) begin errors++; $display("FAIL sel_count: got %0d expected 8", count_h); end
        checks++; if (alloc_index_h !== 5'd8) begin errors++; $display("FAIL sel_alloc_index: got %0d expected 8", alloc_index_h); end
        requests = 32'h0000_00A4;
        step();
        checks++; if (sel_valid_h !== 2'b11) begin errors++; $display("FAIL sel1_valid_h: got %b expected 11", sel_valid_h); end
        checks++; if (sel_index_h !== {5'd5, 5'd2}) begin errors++; $display("FAIL sel1_index_h: got lane0=%0d lane1=%0d expected 2,5", sel_index_h[4:0], sel_index_h[9:5]); end
        checks++; if (sel_valid_t !== 2'b11) begin errors++; $display("FAIL sel1_valid_t: got %b expected 11", sel_valid_t); end
        checks++; if (sel_index_t !== {5'd5, 5'd7}) begin errors++; $display("FAIL sel1_index_t: got lane0=%0d lane1=%0d expected 7,5", sel_index_t[4:0], sel_index_t[9:5]); end
        step();
        checks++; if (sel_valid_h !== 2'b01) begin errors++; $display("FAIL sel2_valid_h: got %b expected 01", sel_valid_h); end
        checks++; if (sel_index_h[4:0] !== 5'd7) begin errors++; $display("FAIL sel2_index_h: got %0d expected 7", sel_index_h[4:0]); end
        checks++; if (sel_valid_t !== 2'b01) begin errors++; $display("FAIL sel2_valid_t: got %b expected 01", sel_valid_t); end
        checks++; if (sel_index_t[4:0] !== 5'd2) begin errors++; $display("FAIL sel2_index_t: got %0d expected 2", sel_index_t[4:0]); end
        requests = 32'h0;
        step();
        checks++; if (sel_valid_h !== 2'b00) begin errors++; $display("FAIL sel3_valid_h: got %b expected 00", sel_valid_h); end
    endtask

    task automatic test_full();
        do_flush();
        checks++; if (count_h !== 6'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_h); end
        alloc_valid = 1'b1;
        repeat (32) step();
        checks++; if (full_h !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", full_h); end
        checks++; if (alloc_ready_h !== 1'b0) begin errors++; $display("FAIL full_alloc_ready: got %0b expected 0", alloc_ready_h); end
        checks++; if (count_h !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", count_h); end
        step();
        checks++; if (count_h !== 6'd32) begin errors++; $display("FAIL full_alloc_ignored: got %0d expected 32", count_h); end
        checks++; if (alloc_index_h !== 5'd0) begin errors++; $display("FAIL full_alloc_index: got %0d expected 0", alloc_index_h); end
        retire_valid = 1'b1;
        step();
        alloc_valid  = 1'b0;
        retire_valid = 1'b0;
        checks++; if (count_h !== 6'd31) begin errors++; $display("FAIL full_alloc_retire_count: got %0d expected 31", count_h); end
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL full_after_retire: got %0b expected 0", full_h); end
        checks++; if (retire_index_h !== 5'd1) begin errors++; $display("FAIL full_retire_index: got %0d expected 1", retire_index_h); end
    endtask

    task automatic test_wrap();
        retire_valid = 1'b1;
        repeat (28) step();
        retire_valid = 1'b0;
        alloc_valid  = 1'b1;
        repeat (3) step();
        alloc_valid  = 1'b0;
        checks++; if (count_h !== 6'd6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", count_h); end
        checks++; if (retire_index_h !== 5'd29) begin errors++; $display("FAIL wrap_head: got %0d expected 29", retire_index_h); end
        checks++; if (alloc_index_h !== 5'd3) begin errors++; $display("FAIL wrap_tail: got %0d expected 3", alloc_index_h); end
        sel_ready = 1'b0;
        requests  = 32'h2000_0003;
        step();
        checks++; if (sel_valid_h !== 2'b11) begin errors++; $display("FAIL wrap_valid_h: got %b expected 11", sel_valid_h); end
        checks++; if (sel_index_h !== {5'd0, 5'd29}) begin errors++; $display("FAIL wrap_index_h: got lane0=%0d lane1=%0d expected 29,0", sel_index_h[4:0], sel_index_h[9:5]); end
        checks++; if (sel_valid_t !== 2'b11) begin errors++; $display("FAIL wrap_valid_t: got %b expected 11", sel_valid_t); end
        checks++; if (sel_index_t !== {5'd0, 5'd1}) begin errors++; $display("FAIL wrap_index_t: got lane0=%0d lane1=%0d expected 1,0", sel_index_t[4:0], sel_index_t[9:5]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pats [3];
        pats[0] = 32'h4000_0004;
        pats[1] = 32'h0000_0006;
        pats[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            requests = pats[i];
            step();
            checks++; if (sel_valid_h !== 2'b11 || sel_index_h !== {5'd0, 5'd29}) begin errors++; $display("FAIL hold_h[%0d]: got valid=%b lane0=%0d lane1=%0d expected 11,29,0", i, sel_valid_h, sel_index_h[4:0], sel_index_h[9:5]); end
            checks++; if (sel_valid_t !== 2'b11 || sel_index_t !== {5'd0, 5'd1}) begin errors++; $display("FAIL hold_t[%0d]: got valid=%b lane0=%0d lane1=%0d expected 11,1,0", i, sel_valid_t, sel_index_t[4:0], sel_index_t[9:5]); end
        end
        sel_ready = 1'b1;
        step();
        checks++; if (sel_index_h !== {5'd31, 5'd30}) begin errors++; $display("FAIL accept1_h: got lane0=%0d lane1=%0d expected 30,31", sel_index_h[4:0], sel_index_h[9:5]); end
        checks++; if (sel_index_t !== {5'd31, 5'd2}) begin errors++; $display("FAIL accept1_t: got lane0=%0d lane1=%0d expected 2,31", sel_index_t[4:0], sel_index_t[9:5]); end
        step();
        checks++; if (sel_valid_h !== 2'b11 || sel_index_h !== {5'd2, 5'd1}) begin errors++; $display("FAIL accept2_h: got valid=%b lane0=%0d lane1=%0d expected 11,1,2", sel_valid_h, sel_index_h[4:0], sel_index_h[9:5]); end
        checks++; if (sel_valid_t !== 2'b11 || sel_index_t !== {5'd29, 5'd30}) begin errors++; $display("FAIL accept2_t: got valid=%b lane0=%0d lane1=%0d expected 11,30,29", sel_valid_t, sel_index_t[4:0], sel_index_t[9:5]); end
        step();
        checks++; if (sel_valid_h !== 2'b00) begin errors++; $display("FAIL accept3_valid_h: got %b expected 00", sel_valid_h); end
        checks++; if (sel_valid_t !== 2'b00) begin errors++; $display("FAIL accept3_valid_t: got %b expected 00", sel_valid_t); end
        sel_ready = 1'b0;
        requests  = 32'h0;
    endtask

    task automatic test_flush();
        do_flush();
        alloc_valid = 1'b1;
        repeat (10) step();
        alloc_valid = 1'b0;
        checks++; if (count_h !== 6'd10) begin errors++; $display("FAIL flush_pre_count: got %0d expected 10", count_h); end
        requests = 32'h3;
        step();
        checks++; if (sel_valid_h !== 2'b11) begin errors++; $display("FAIL flush_pre_valid: got %b expected 11", sel_valid_h); end
        flush        = 1'b1;
        alloc_valid  = 1'b1;
        retire_valid = 1'b1;
        step();
        flush        = 1'b0;
        retire_valid = 1'b0;
        checks++; if (count_h !== 6'd0 || empty_h !== 1'b1) begin errors++; $display("FAIL flush_count: got count=%0d empty=%0b expected 0,1", count_h, empty_h); end
        checks++; if (alloc_index_h !== 5'd0 || retire_index_h !== 5'd0) begin errors++; $display("FAIL flush_ptrs: got tail=%0d head=%0d expected 0,0", alloc_index_h, retire_index_h); end
        checks++; if (sel_valid_h !== 2'b00 || sel_valid_t !== 2'b00) begin errors++; $display("FAIL flush_sel_valid: got %b/%b expected 00/00", sel_valid_h, sel_valid_t); end
        sel_ready = 1'b1;
        step();
        checks++; if (sel_valid_h !== 2'b00) begin errors++; $display("FAIL post_flush_a: got %b expected 00", sel_valid_h); end
        step();
        alloc_valid = 1'b0;
        checks++; if (sel_valid_h !== 2'b01 || sel_index_h[4:0] !== 5'd0) begin errors++; $display("FAIL post_flush_b: got valid=%b lane0=%0d expected 01,0", sel_valid_h, sel_index_h[4:0]); end
        checks++; if (count_h !== 6'd2) begin errors++; $display("FAIL post_flush_count: got %0d expected 2", count_h); end
        step();
        checks++; if (sel_valid_h !== 2'b01 || sel_index_h[4:0] !== 5'd1) begin errors++; $display("FAIL post_flush_c: got valid=%b lane0=%0d expected 01,1", sel_valid_h, sel_index_h[4:0]); end
        requests  = 32'h0;
        sel_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_flush();
        alloc_valid = 1'b1;
        repeat (7) step();
        alloc_valid = 1'b0;
        requests    = 32'h3;
        step();
        checks++; if (count_h !== 6'd7 || sel_valid_h !== 2'b11) begin errors++; $display("FAIL areset_pre: got count=%0d valid=%b expected 7,11", count_h, sel_valid_h); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count_h !== 6'd0 || empty_h !== 1'b1 || full_h !== 1'b0) begin errors++; $display("FAIL areset_count: got count=%0d empty=%0b full=%0b expected 0,1,0", count_h, empty_h, full_h); end
        checks++; if (alloc_ready_h !== 1'b1) begin errors++; $display("FAIL areset_alloc_ready: got %0b expected 1", alloc_ready_h); end
        checks++; if (sel_valid_h !== 2'b00 || sel_index_h !== 10'd0) begin errors++; $display("FAIL areset_sel: got valid=%b index=%0h expected 00,0", sel_valid_h, sel_index_h); end
        checks++; if (sel_valid_t !== 2'b00 || sel_index_t !== 10'd0) begin errors++; $display("FAIL areset_sel_t: got valid=%b index=%0h expected 00,0", sel_valid_t, sel_index_t); end
        requests = 32'h0;
        #2;
        reset = 1'b1;
        step();
        checks++; if (alloc_index_h !== 5'd0 || empty_h !== 1'b1) begin errors++; $display("FAIL areset_release: got alloc_index=%0d empty=%0b expected 0,1", alloc_index_h, empty_h); end
    endtask

    initial begin
        clock        = 1'b0;
        reset        = 1'b0;
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        retire_valid = 1'b0;
        requests     = 32'h0;
        sel_ready    = 1'b0;
        #12;
        reset = 1'b1;
        step();
        test_reset();
        test_select_head();
        test_full();
        test_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_window_select.md
Name: fifo_window_select

Overview:
- Sequential successor to the combinational circular-FIFO priority encoder used in the out-of-order core.
- Owns the head/tail pointers of a circular buffer with SLOTS entries and handles allocate and retire.
- Each cycle it picks up to GRANTS requesting entries inside the live window, oldest-first or youngest-first, and presents them through a registered valid/ready output stage.
- Used by issue queues and load/store queues to choose entries for multi-issue dispatch. Entries already granted are never re-selected.

Parameters:
- ADDR_WIDTH, 5, log2 of buffer depth.
- SLOTS, 1<<ADDR_WIDTH, number of entries. Must be a power of two.
- GRANTS, 2, number of selection lanes per cycle, 1..4.
- CLOSEST_TO, "head", "head" means oldest-first; "tail" means youngest-first.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the whole buffer.
- alloc_valid  in  1  request to allocate the entry at tail.
- alloc_ready  out  1  high when not full.
- alloc_index  out  ADDR_WIDTH  slot that will be allocated (tail).
- retire_valid  in  1  request to free the entry at head.
- retire_index  out  ADDR_WIDTH  slot that will be freed (head).
- requests  in  SLOTS  per-slot "ready to be selected" wires.
- sel_valid  out  GRANTS  per-lane valid. Lanes are packed contiguously from lane 0.
- sel_index  out  GRANTS*ADDR_WIDTH  lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- sel_ready  in  1  consumer accepts all valid lanes this cycle.
- count  out  ADDR_WIDTH+1  number of occupied entries, 0..SLOTS.
- empty  out  1  count == 0.
- full  out  1  count == SLOTS.

Behaviour:
- Reset (reset low, asynchronous):
  - head = tail = 0, granted mask = 0, sel_valid = 0, sel_index = 0.
  - count = 0, empty = 1, full = 0, alloc_ready = 1.
- Pointers:
  - head and tail are ADDR_WIDTH+1 bits; the extra bit is the wrap flag.
  - empty when head == tail. full when the low bits are equal and the wrap bits differ. This removes the head==tail ambiguity.
  - count = tail - head, taken modulo 2^(ADDR_WIDTH+1).
- Allocate:
  - Fires when alloc_valid && !full. tail increments and granted[tail] is cleared.
  - Allocation while full is ignored; no bypass from a same-cycle retire.
- Retire:
  - Fires when retire_valid && !empty. head increments.
  - Retire while empty is ignored.
  - Allocate and retire in the same cycle are both honoured; count is unchanged.
- Flush:
  - Takes effect at the clock edge and has priority over allocate, retire and selection.
  - head = tail = 0, granted = 0, sel_valid = 0.
- Window:
  - A slot is live if it lies in [head, tail-1] modulo SLOTS. This handles wrap-around where head > tail.
  - When full, every slot is live.
- Eligible set: requests & live & ~granted.
- Selection:
  - Scan the eligible set in circular order.
  - With "head", lane 0 gets the eligible slot nearest head, lane 1 the next, and so on.
  - With "tail", lane 0 gets the eligible slot nearest tail-1, scanning toward head.
  - If fewer than GRANTS slots are eligible, the upper lanes are invalid.
- Output stage:
  - Loads when no lane is valid or sel_ready is high. Otherwise it holds; the values stay stable until accepted.
  - When a selection loads, the granted bit is set for every loaded valid lane. This takes effect in the same edge, so those slots cannot be chosen in the next selection.
  - Latency: requests asserted in cycle N appear on sel_* in cycle N+1 if the stage loads.
  - A slot allocated in cycle N is live and eligible from cycle N+1.
- Usage requirements:
  - The consumer must not retire a slot that is still presented on sel_* and not yet accepted.
  - requests for non-live slots are ignored.
  - alloc_index and retire_index are combinational from the registered pointers.

Test Plan:
- Reset low mid-run with count=7 and sel_valid=2'b11 -> all outputs return to reset values immediately, asynchronously; after release, alloc_index=0 and empty=1.
- GRANTS=2, "head": allocate 8 entries, head=0, requests=0x0000_00A4 -> next cycle sel_index lane0=2, lane1=5, sel_valid=2'b11. With sel_ready=1, the following selection gives lane0=7, sel_valid=2'b01.
- Wrap case: head=29, tail=3, requests=0x2000_0003 (slots 0, 1, 29) -> "head" selects 29 then 0. "tail" selects 1 then 0.
- Backpressure: sel_ready=0 for 3 cycles while requests change -> sel_index and sel_valid stay constant. Upon acceptance, the next selection excludes the previously granted slots.
- Fill all 32 slots -> full=1, alloc_ready=0, count=32. alloc_valid ignored. alloc+retire together while full -> only retire occurs (count=31).
- Simultaneous flush, alloc_valid and retire_valid with count=10 -> next cycle count=0, head=tail=0, sel_valid=0, granted cleared.
